// File: rtl/seq_pkg.sv
// Shared definitions for the CPU sequencer.
//   - state_t      : sequencer FSM states
//   - OP_*         : 4-bit opcode constants (instruction bits [8:5])
//   - PC_W_DEF     : default program-counter width
//   - IW_DEF       : default instruction width
//   - is_mem_op()  : true for opcodes that need a data-memory transfer
package seq_pkg;

    localparam int PC_W_DEF = 10;
    localparam int IW_DEF   = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    // Opcodes carry an OP_ prefix so OP_HALT cannot collide with the HALT state.
    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_CMP   = 4'b1011;
    localparam logic [3:0] OP_JLT   = 4'b1100;
    localparam logic [3:0] OP_JEQ   = 4'b1101;
    localparam logic [3:0] OP_JGT   = 4'b1110;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/prog_counter.sv
// Program counter register.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset, clears the PC
//   clr_i    : load 0 (start of execution)
//   load_i   : load target_i (taken branch)
//   inc_i    : advance by one, wrapping modulo 2^PC_W
//   target_i : branch target
//   pc_o     : current program counter
// Priority: clr_i > load_i > inc_i; with none asserted the PC holds.
module prog_counter #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            clr_i,
    input  logic            load_i,
    input  logic            inc_i,
    input  logic [PC_W-1:0] target_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clr_i) begin
            pc_d = '0;
        end else if (load_i) begin
            pc_d = target_i;
        end else if (inc_i) begin
            // Natural overflow of the PC_W-bit add gives the wrap to 0.
            pc_d = pc_q + PC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH -> DECODE -> EXEC -> (MEM) -> WB.
// Ports:
//   clk, reset_n           : clock / async active-low reset
//   start                  : begin (or restart) at PC 0, honoured in IDLE/HALT only
//   instr_in               : ROM data at pc_out (combinational ROM)
//   ir_out                 : latched instruction register
//   pc_out                 : program counter
//   branch_in, lut_target  : decoder branch decision and target
//   reg_write_in/acc_write_in -> reg_wr_en/acc_wr_en : write strobes, WB only
//   cmp_en                 : compare-flag update, one cycle in EXEC for OP_CMP
//   mem_req, mem_we, mem_ack : data-memory handshake
//   busy, done             : running / halted status
//   retired                : saturating retired-instruction count
//   dbg_state_o            : current FSM state, for observation
//   dbg_retired_load_i/dbg_retired_val_i : overwrite the retired counter
//
// Memory handshake: mem_req is high for every cycle spent in MEM and is
// decoded from state only (no path from mem_ack). The transfer completes on
// the rising edge where mem_ack=1 while in MEM, which may be the first MEM
// cycle; mem_ack seen in any other state is ignored.
module cpu_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W = PC_W_DEF,
    parameter int IW   = IW_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [IW-1:0]   instr_in,
    output logic [IW-1:0]   ir_out,
    output logic [PC_W-1:0] pc_out,
    input  logic            branch_in,
    input  logic [PC_W-1:0] lut_target,
    input  logic            reg_write_in,
    input  logic            acc_write_in,
    output logic            reg_wr_en,
    output logic            acc_wr_en,
    output logic            cmp_en,
    output logic            mem_req,
    output logic            mem_we,
    input  logic            mem_ack,
    output logic            busy,
    output logic            done,
    output logic [15:0]     retired,
    output state_t          dbg_state_o,
    input  logic            dbg_retired_load_i,
    input  logic [15:0]     dbg_retired_val_i
);

    state_t        state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic [15:0]   retired_q, retired_d;
    logic          pc_clr, pc_load, pc_inc;
    logic [3:0]    opcode;
    logic [15:0]   retired_inc;

    assign opcode      = ir_q[8:5];
    assign retired_inc = (retired_q == 16'hFFFF) ? retired_q : retired_q + 16'd1;

    prog_counter #(
        .PC_W(PC_W)
    ) u_pc (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr_i    (pc_clr),
        .load_i   (pc_load),
        .inc_i    (pc_inc),
        .target_i (lut_target),
        .pc_o     (pc_out)
    );

    // Next-state, IR, counter and PC control.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        pc_clr    = 1'b0;
        pc_load   = 1'b0;
        pc_inc    = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    state_d   = FETCH;
                    pc_clr    = 1'b1;
                    retired_d = '0;
                end
            end
            FETCH: begin
                ir_d    = instr_in;
                state_d = DECODE;
            end
            DECODE: begin
                state_d = EXEC;
            end
            EXEC: begin
                if (opcode == OP_HALT) begin
                    // The halt instruction retires as it enters HALT.
                    state_d   = HALT;
                    retired_d = retired_inc;
                end else if (is_mem_op(opcode)) begin
                    state_d = MEM;
                end else begin
                    state_d = WB;
                end
            end
            MEM: begin
                if (mem_ack) begin
                    state_d = WB;
                end
            end
            WB: begin
                state_d   = FETCH;
                retired_d = retired_inc;
                if (branch_in) begin
                    pc_load = 1'b1;
                end else begin
                    pc_inc = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (dbg_retired_load_i) begin
            retired_d = dbg_retired_val_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Outputs decoded from state (and the registered IR). Because state_q
    // resets asynchronously, every strobe drops as soon as reset_n falls.
    always_comb begin
        reg_wr_en = 1'b0;
        acc_wr_en = 1'b0;
        cmp_en    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            FETCH, DECODE: begin
                busy = 1'b1;
            end
            EXEC: begin
                busy   = 1'b1;
                cmp_en = (opcode == OP_CMP);
            end
            MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = (opcode == OP_STORE);
            end
            WB: begin
                busy      = 1'b1;
                reg_wr_en = reg_write_in;
                acc_wr_en = acc_write_in;
            end
            HALT: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign ir_out      = ir_q;
    assign retired     = retired_q;
    assign dbg_state_o = state_q;

endmodule
